// File: rtl/inst_fetch_unit_if.sv
// Fetch bus between inst_fetch_unit, the instruction cache and decode:
// cache pointer/answer, branch redirect, and the prefetch head toward decode.
interface inst_fetch_unit_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] ic_ptr;
  logic [WORD_SIZE-1:0] ic_data;
  logic                 ic_hit;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 inst_valid;
  logic [WORD_SIZE-1:0] inst_data;
  logic [WORD_SIZE-1:0] inst_pc;
  logic                 inst_ready;

  modport master (
    output ic_ptr,
    input  ic_data,
    input  ic_hit,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  ic_ptr,
    output ic_data,
    output ic_hit,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch PC sequencer with a prefetch FIFO toward decode; redirects flush the FIFO.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module inst_fetch_unit #(
  parameter int                   WORD_SIZE  = 32,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_miss_cyc
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, STALL} state_t;

  logic [WORD_SIZE-1:0] r_fetch_pc;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW-1:0]        r_wr_ptr;
  logic [CW-1:0]        r_count;
  logic [WORD_SIZE-1:0] r_inst_pc;
  logic [WORD_SIZE-1:0] r_inst_data;
  logic [WORD_SIZE-1:0] r_mem_pc   [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] r_mem_data [FIFO_DEPTH];

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  state_t        w_state;
  logic [CW-1:0] w_cnt_after_pop;
  logic [AW-1:0] w_rd_next;

  always_comb begin
    w_full          = (r_count == CW'(FIFO_DEPTH));
    w_pop           = bus.inst_valid & bus.inst_ready;
    w_state         = (!bus.ic_hit || (w_full && !w_pop)) ? STALL : RUN;
    w_push          = !bus.redirect_valid && (w_state == RUN);
    w_cnt_after_pop = r_count - CW'(w_pop);
    w_rd_next       = r_rd_ptr + AW'(w_pop);
  end

  assign bus.ic_ptr     = r_fetch_pc;
  assign bus.inst_valid = (r_count != '0);
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_data  = r_inst_data;

  // Head registers preload the entry decode will see next cycle, so they keep
  // the last shown word once the FIFO runs dry or is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_inst_pc   <= '0;
      r_inst_data <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_count <= w_cnt_after_pop + CW'(w_push);
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_fetch_pc <= r_fetch_pc + WORD_SIZE'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_cnt_after_pop != '0) begin
        r_inst_pc   <= r_mem_pc[w_rd_next];
        r_inst_data <= r_mem_data[w_rd_next];
      end else if (w_push) begin
        r_inst_pc   <= r_fetch_pc;
        r_inst_data <= bus.ic_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      r_mem_data[r_wr_ptr] <= bus.ic_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_miss_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched  <= '0;
      r_perf_miss_cyc <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (!bus.ic_hit && !bus.redirect_valid) begin
        r_perf_miss_cyc <= r_perf_miss_cyc + 32'd1;
      end
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_miss_cyc = r_perf_miss_cyc;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed scoreboard bench for inst_fetch_unit: a cache model answers each
// pointer, expected words are queued at push and compared when decode pops.
module tb_inst_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  entry_t      sb[$];
  logic [31:0] mPc;
  logic [31:0] lastPc;
  logic [31:0] lastData;
  logic [31:0] mFetched;
  logic [31:0] mMiss;

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched;
  logic [31:0] perfMissCyc;
`endif

  inst_fetch_unit_if #(.WORD_SIZE(32)) bus ();

  inst_fetch_unit #(
    .WORD_SIZE (32),
    .FIFO_DEPTH(4),
    .RESET_PC  (32'd0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perfFetched),
    .perf_miss_cyc(perfMissCyc)
`endif
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign bus.ic_data = memWord(bus.ic_ptr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check against the model,
  // then advance the model to match the next rising edge.
  task automatic applyStimulus(input logic hit, input logic ready,
                               input logic redir, input logic [31:0] rpc);
    entry_t e;
    logic   full;
    logic   pop;
    bus.ic_hit         = hit;
    bus.inst_ready     = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    checkOutput("ic_ptr", bus.ic_ptr, mPc);
    checkOutput("inst_valid", {31'd0, bus.inst_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      lastPc   = sb[0].pc;
      lastData = sb[0].data;
    end
    checkOutput("inst_pc", bus.inst_pc, lastPc);
    checkOutput("inst_data", bus.inst_data, lastData);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", perfFetched, mFetched);
    checkOutput("perf_miss_cyc", perfMissCyc, mMiss);
`endif
    full = (sb.size() == 4);
    pop  = ready && (sb.size() != 0);
    if (pop) begin
      e = sb.pop_front();
    end
    if (!hit && !redir) begin
      mMiss++;
    end
    if (redir) begin
      sb.delete();
      mPc = rpc;
    end else if (hit && (!full || pop)) begin
      e.pc   = mPc;
      e.data = memWord(mPc);
      sb.push_back(e);
      mPc = mPc + 32'd1;
      mFetched++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    mPc      = 32'd0;
    lastPc   = 32'd0;
    lastData = 32'd0;
    mFetched = 32'd0;
    mMiss    = 32'd0;
    checkOutput("reset_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    checkOutput("reset_ic_ptr", bus.ic_ptr, 32'd0);
    checkOutput("reset_inst_pc", bus.inst_pc, 32'd0);
    checkOutput("reset_inst_data", bus.inst_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.ic_hit         = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    @(negedge clk);
    doReset();

    // Streaming: one word per cycle once the first one lands.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

    // Build up three queued entries, then reset mid-run.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("queued_before_reset", sb.size(), 32'd3);
    @(posedge clk);
    #2;
    doReset();

    // Backpressure: four pushes then frozen pointer, then push+pop together.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("bp_ptr_frozen", bus.ic_ptr, 32'd4);
    checkOutput("bp_head_pc", bus.inst_pc, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect with a pop in the same cycle, landing at 33; then miss stall.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd33);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("miss_ptr_after_hit", bus.ic_ptr, 32'd34);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

    // Redirect with three entries queued and a hit that must be discarded.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd20);
    checkOutput("redir_ptr", bus.ic_ptr, 32'd20);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("redir_first_pc", bus.inst_pc, 32'd20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

    // PC wrap from all-ones to zero, with counters observed from reset.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("wrap_ptr", bus.ic_ptr, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("wrap_head_after_pop", bus.inst_pc, 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("wrap_perf_fetched", perfFetched, 32'd2);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
